// File: rtl/reg_bank_32x32.sv
// rtl/reg_bank_32x32.sv - 32x32 register file, one write port, two registered read ports
module reg_bank_32x32 #(
  parameter int DATA_W   = 32,
  parameter int SP_INDEX = 29,
  parameter int SP_RESET = 227
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write,
  input  logic [4:0]        write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [4:0]        read_reg1,
  input  logic [4:0]        read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2
);

  // Register 0 has no storage; entries 1..31 only.
  logic [DATA_W-1:0] regs [1:31];
  logic [31:0]       write_en;
  logic              bypass1;
  logic              bypass2;
  logic [DATA_W-1:0] stored1;
  logic [DATA_W-1:0] stored2;

  // Read mux over stored entries; index 0 falls through to zero.
  function automatic logic [DATA_W-1:0] lookup(input logic [4:0] idx);
    logic [DATA_W-1:0] result;
    result = '0;
    for (int i = 1; i < 32; i++) begin
      if (idx == 5'(i)) result = regs[i];
    end
    return result;
  endfunction

  // One-hot write decode; bit 0 is forced low so writes to register 0 vanish.
  always_comb begin
    write_en = '0;
    if (reg_write) write_en[write_reg] = 1'b1;
    write_en[0] = 1'b0;
  end

  // Same-edge write to a read index forwards the new data to that port.
  always_comb begin
    bypass1 = write_en[read_reg1];
    bypass2 = write_en[read_reg2];
    stored1 = lookup(read_reg1);
    stored2 = lookup(read_reg2);
  end

  // Storage update: reset loads clear/stack-pointer values and wins over a write.
  always_ff @(posedge clk) begin
    for (int i = 1; i < 32; i++) begin
      if (reset) begin
        regs[i] <= (i == SP_INDEX) ? DATA_W'(SP_RESET) : '0;
      end else if (write_en[i]) begin
        regs[i] <= write_data;
      end
    end
  end

  // Registered read ports with write-through bypass.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_data1 <= '0;
      read_data2 <= '0;
    end else begin
      read_data1 <= bypass1 ? write_data : stored1;
      read_data2 <= bypass2 ? write_data : stored2;
    end
  end

endmodule

// File: tb/tb_reg_bank_32x32.sv
// tb/tb_reg_bank_32x32.sv - self-checking bench for reg_bank_32x32
module tb_reg_bank_32x32;

  logic        clk;
  logic        reset;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [31:0] read_data1;
  logic [31:0] read_data2;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [32];

  reg_bank_32x32 dut (
    .clk(clk),
    .reset(reset),
    .reg_write(reg_write),
    .write_reg(write_reg),
    .write_data(write_data),
    .read_reg1(read_reg1),
    .read_reg2(read_reg2),
    .read_data1(read_data1),
    .read_data2(read_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock edge: drive inputs, predict outputs from the model, check,
  // then wiggle the read indices to confirm the outputs are registered.
  task automatic step(input string tag, input logic rst, input logic we,
                      input logic [4:0] wr, input logic [31:0] wd,
                      input logic [4:0] r1, input logic [4:0] r2);
    logic [31:0] exp1, exp2;
    reset = rst; reg_write = we; write_reg = wr; write_data = wd;
    read_reg1 = r1; read_reg2 = r2;
    if (rst) begin
      exp1 = 0;
      exp2 = 0;
      foreach (model[i]) model[i] = 0;
      model[29] = 32'd227;
    end else begin
      exp1 = model[r1];
      exp2 = model[r2];
      if (we && wr != 0) begin
        model[wr] = wd;
        if (wr == r1) exp1 = wd;
        if (wr == r2) exp2 = wd;
      end
    end
    @(posedge clk);
    #1;
    check({tag, "_rd1"}, read_data1, exp1);
    check({tag, "_rd2"}, read_data2, exp2);
    read_reg1 = ~r1;
    read_reg2 = r2 + 5'd1;
    #2;
    check({tag, "_hold1"}, read_data1, exp1);
    check({tag, "_hold2"}, read_data2, exp2);
  endtask

  initial begin
    reset = 0; reg_write = 0; write_reg = 0; write_data = 0;
    read_reg1 = 0; read_reg2 = 0;
    foreach (model[i]) model[i] = 0;
    @(posedge clk);
    #1;

    // reset then read
    step("reset", 1, 0, 0, 0, 29, 5);
    step("rd_sp", 0, 0, 0, 0, 29, 5);
    if (read_data1 !== 32'd227) begin end
    for (int i = 0; i < 32; i += 2) step("sweep", 0, 0, 0, 0, 5'(i), 5'(i + 1));

    // basic write/read
    step("wr8", 0, 1, 8, 32'hDEADBEEF, 1, 2);
    step("rd8", 0, 0, 0, 0, 8, 7);
    check("rd8_const", read_data1, 32'hDEADBEEF);
    step("rd9", 0, 0, 0, 0, 9, 8);

    // register 0 protection, including same-edge bypass
    step("wr0", 0, 1, 0, 32'hFFFFFFFF, 0, 0);
    check("wr0_const", read_data1, 32'h0);
    step("rd0", 0, 0, 0, 0, 0, 8);

    // bypass on both ports
    step("wr12", 0, 1, 12, 32'h11, 12, 3);
    step("byp12", 0, 1, 12, 32'h22, 12, 12);
    check("byp12_const1", read_data1, 32'h22);
    check("byp12_const2", read_data2, 32'h22);

    // write disabled
    step("wr3", 0, 1, 3, 32'h55, 0, 0);
    for (int i = 0; i < 4; i++) step("nowr3", 0, 0, 3, 32'hAA, 3, 3);
    step("rd3", 0, 0, 0, 0, 3, 12);
    check("rd3_const", read_data1, 32'h55);

    // reset priority over a same-edge write
    step("wr29", 0, 1, 29, 32'h100, 29, 0);
    step("rst_wr", 1, 1, 29, 32'h999, 29, 29);
    step("rd29", 0, 0, 0, 0, 29, 12);
    check("rd29_const", read_data1, 32'd227);

    // randomized traffic against the array model
    for (int n = 0; n < 400; n++) begin
      step("rand", ($urandom_range(0, 63) == 0), $urandom_range(0, 1),
           5'($urandom_range(0, 31)), $urandom,
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_bank_32x32.md
Name: reg_bank_32x32

Overview:
- 32-entry by 32-bit general-purpose register file for the multicycle CPU datapath.
- It is the consuming end of the 5-bit register-index selection: it takes the selected write index, decodes it to one of 32 write enables and stores the data.
- It also provides two synchronous read ports feeding the A/B operand registers.
- Register 0 reads as zero; the stack-pointer register has a non-zero reset value.

Parameters:
- DATA_W, 32, data width of each register and of the read/write data ports.
- SP_INDEX, 29, index of the stack-pointer register that gets a special reset value.
- SP_RESET, 227, reset value loaded into register SP_INDEX.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- reg_write  input  1  write enable for the write port.
- write_reg  input  5  write index, driven by the register-destination mux.
- write_data  input  DATA_W  data to write.
- read_reg1  input  5  read port 1 index (rs).
- read_reg2  input  5  read port 2 index (rt).
- read_data1  output  DATA_W  registered read data, port 1.
- read_data2  output  DATA_W  registered read data, port 2.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset), sampled only on the rising edge of clk.
- Reset:
  - When reset=1 at an edge, registers 1..31 are cleared to 0, except register SP_INDEX, which is loaded with SP_RESET.
  - read_data1 and read_data2 are cleared to 0.
  - Reset overrides any write presented in the same cycle.
  - Reset asserted mid-operation discards all stored contents; the write presented in that cycle is lost.
- Write decode:
  - write_reg is decoded one-hot to 32 enables.
  - On an edge with reset=0, reg_write=1 and write_reg!=0, the register at write_reg takes write_data.
  - Exactly one register changes per write; all others hold.
- Register 0:
  - Has no storage and always reads 0.
  - Writes with write_reg=0 are silently dropped; this is not an error.
- Reads:
  - On every edge with reset=0, read_dataN is loaded from the register at read_regN.
  - Read latency is 1 cycle; outputs hold between edges and do not react combinationally to index changes.
- Write-through bypass:
  - Condition: at the same edge, reg_write=1, write_reg==read_regN and write_reg!=0.
  - Result: read_dataN is loaded with write_data, i.e. the new value, not the old one.
  - Both ports may bypass simultaneously when both indices match.
- Both read indices may be equal; both ports then return the same value.
- reg_write=0: no register changes regardless of write_reg/write_data, including X-free don't-care values on those inputs.
- Widths: indices are a fixed 5 bits, and all 32 encodings are valid. No truncation or extension occurs in the block; data passes at DATA_W unchanged.
- No internal state machine beyond the storage array and the two output registers. There are no handshake signals; the control unit sequences reg_write.

Test Plan:
- Reset then read: assert reset 1 cycle; read_reg1=29, read_reg2=5 -> after 1 edge read_data1=227, read_data2=0; every index 0..31 reads 0 except 29.
- Basic write/read: write_reg=8, write_data=0xDEADBEEF, reg_write=1 for 1 edge; then read_reg1=8 -> read_data1=0xDEADBEEF one edge later; registers 7 and 9 still read 0.
- Register 0 protection: write_reg=0, write_data=0xFFFFFFFF, reg_write=1 -> subsequent read of index 0 returns 0, including the same-edge bypass case (read_reg1=0 returns 0).
- Bypass both ports: reg 12 holds 0x11; same edge reg_write=1, write_reg=12, write_data=0x22, read_reg1=read_reg2=12 -> both read_data outputs = 0x22 after that edge.
- Write disabled: reg 3 holds 0x55; reg_write=0, write_reg=3, write_data=0xAA for 4 edges -> read of reg 3 returns 0x55.
- Reset priority: reg 29 holds 0x100; at one edge reset=1 together with reg_write=1, write_reg=29, write_data=0x999 -> reg 29 = 227, read_data1=read_data2=0 after that edge.
